// File: rtl/spi_txn_arbiter.sv
// ============================================================================
// Module      : spi_txn_arbiter
// Description : Round-robin arbiter and transaction sequencer sharing a single
//               SPI master among NUM_REQ requesters, with a WAIT watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_txn_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          start_m,
    output logic [DATA_WIDTH-1:0]         data_m_in,
    input  logic                          finish_m,
    input  logic [DATA_WIDTH-1:0]         data_m_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [WD_W-1:0]  c_WD_LAST  = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   c_NUM_REQ  = (IDX_W + 1)'(NUM_REQ);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LAUNCH = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [WD_W-1:0]       r_wd;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic                  w_timeout;
    logic                  w_win_found;
    logic [IDX_W-1:0]      w_win_idx;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [IDX_W:0]        w_dist;
    logic [IDX_W:0]        w_best_dist;

    // Winner = requester with the smallest circular distance upward from ptr.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_dist      = '0;
        w_best_dist = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) >= r_ptr) begin
                w_dist = {1'b0, IDX_W'(i) - r_ptr};
            end else begin
                w_dist = {1'b0, IDX_W'(i)} + c_NUM_REQ - {1'b0, r_ptr};
            end
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_win_idx   = IDX_W'(i);
                w_win_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_wd == c_WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_win_found) w_next = c_LAUNCH;
            c_LAUNCH: w_next = c_WAIT;
            c_WAIT:   if (finish_m || w_timeout) w_next = c_DONE;
            c_DONE:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_comb begin
        start_m   = (r_state == c_LAUNCH);
        busy      = (r_state != c_IDLE);
        rsp_valid = (r_state == c_DONE) ? r_gnt : '0;
        rsp_err   = (r_state == c_DONE) && r_err;
        gnt       = r_gnt;
        rsp_data  = r_rsp_data;
    end

    // Transaction datapath: captured grant/word, watchdog, response, RR pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_gnt      <= '0;
            r_wd       <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
            data_m_in  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_win_found) begin
                        r_gnt     <= NUM_REQ'(1) << w_win_idx;
                        r_idx     <= w_win_idx;
                        data_m_in <= w_win_data;
                    end
                end
                c_LAUNCH: begin
                    r_wd <= '0;
                end
                c_WAIT: begin
                    if (finish_m) begin
                        r_rsp_data <= data_m_out;
                        r_err      <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_err      <= 1'b1;
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                c_DONE: begin
                    r_gnt <= '0;
                    r_err <= 1'b0;
                    r_ptr <= (r_idx == c_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
// ============================================================================
// Module      : tb_spi_txn_arbiter
// Description : Randomized self-checking bench for spi_txn_arbiter against a
//               round-robin reference model and a scripted SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_txn_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          start_m;
    logic [DW-1:0] data_m_in;
    logic          finish_m;
    logic [DW-1:0] data_m_out;

    int runs  = 0;
    int fails = 0;
    int m_ptr = 0;
    logic [DW-1:0] dat [N];

    spi_txn_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .start_m(start_m), .data_m_in(data_m_in),
        .finish_m(finish_m), .data_m_out(data_m_out)
    );

    always #5 clk = ~clk;

    // Reference arbitration: first pending requester scanning upward from ptr.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_data(input int i, input logic [DW-1:0] w);
        dat[i] = w;
        req_data[i*DW +: DW] = w;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (start_m) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called in the start_m cycle; raises finish_m for the lat-th cycle after it.
    task automatic finish_after(input int lat, input logic [DW-1:0] w);
        repeat (lat - 1) @(negedge clk);
        finish_m   = 1'b1;
        data_m_out = w;
        @(negedge clk);
        finish_m   = 1'b0;
        data_m_out = DW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; finish_m = 1'b0; data_m_out = '0; req_data = '0;
        repeat (3) @(negedge clk);
        runs++;
        if ({gnt, rsp_valid, rsp_err, start_m, data_m_in, rsp_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b err=%b st=%b dmi=%h rd=%h want all 0",
                     gnt, rsp_valid, rsp_err, start_m, data_m_in, rsp_data);
        end
        runs++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        set_data(0, 8'hA5);
        req = 4'b0001;
        @(negedge clk);
        runs++;
        if ({start_m, gnt, data_m_in} !== {1'b1, 4'b0001, 8'hA5}) begin
            fails++;
            $display("FAIL single_launch: got st=%b gnt=%b dmi=%h want 1 0001 a5", start_m, gnt, data_m_in);
        end
        @(negedge clk);
        runs++;
        if (start_m !== 1'b0) begin
            fails++; $display("FAIL single_start_width: got %b want 0", start_m);
        end
        finish_m = 1'b1; data_m_out = 8'h3C;
        @(negedge clk);
        finish_m = 1'b0;
        runs++;
        if ({rsp_valid, rsp_data, rsp_err} !== {4'b0001, 8'h3C, 1'b0}) begin
            fails++;
            $display("FAIL single_rsp: got rv=%b rd=%h err=%b want 0001 3c 0", rsp_valid, rsp_data, rsp_err);
        end
        req = '0;
        @(negedge clk);
        runs++;
        if ({busy, gnt, rsp_valid} !== '0) begin
            fails++; $display("FAIL single_idle: got busy=%b gnt=%b rv=%b want 0", busy, gnt, rsp_valid);
        end
        m_ptr = 1;
    endtask

    // Generic arbitration scenario: contention, persistent requests, random arrivals.
    task automatic test_arbitration(input string name, input bit rst_first, input logic [N-1:0] init,
                                    input int ntx, input bit persist, input bit arrivals);
        logic [N-1:0]  pending, fresh;
        logic [DW-1:0] w;
        int            exp, lat;
        bit            ok;
        if (rst_first) do_reset();
        pending = init;
        for (int i = 0; i < N; i++) if (pending[i]) set_data(i, DW'($urandom));
        req = pending;
        for (int t = 0; t < ntx; t++) begin
            wait_start(ok);
            runs++;
            if (!ok) begin
                fails++; $display("FAIL %s start_timeout: txn %0d no start_m", name, t);
                req = '0;
                return;
            end
            exp = pick(pending, m_ptr);
            runs++;
            if (gnt !== 4'(1 << exp) || data_m_in !== dat[exp]) begin
                fails++;
                $display("FAIL %s grant: txn %0d got gnt=%b dmi=%h want %b %h",
                         name, t, gnt, data_m_in, 4'(1 << exp), dat[exp]);
            end
            lat = $urandom_range(2, TO + 1);
            w   = DW'($urandom);
            finish_after(lat, w);
            runs++;
            if ({rsp_valid, rsp_data, rsp_err} !== {4'(1 << exp), w, 1'b0}) begin
                fails++;
                $display("FAIL %s rsp: txn %0d lat %0d got rv=%b rd=%h err=%b want %b %h 0",
                         name, t, lat, rsp_valid, rsp_data, rsp_err, 4'(1 << exp), w);
            end
            m_ptr = (exp + 1) % N;
            if (!persist) pending[exp] = 1'b0;
            if (arrivals) begin
                fresh = 4'($urandom) & ~pending;
                if ((pending | fresh) == '0) fresh[$urandom_range(0, N-1)] = 1'b1;
                for (int i = 0; i < N; i++) if (fresh[i]) set_data(i, DW'($urandom));
                pending = pending | fresh;
            end
            if (t == ntx - 1) pending = '0;
            req = pending;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int c;
        logic [DW-1:0] w;
        set_data(2, 8'h77);
        req = 4'b0100;
        wait_start(ok);
        c = 0;
        while (ok && rsp_valid === '0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        runs++;
        if (!ok || c != TO + 1) begin
            fails++; $display("FAIL timeout_latency: got %0d cycles (start ok=%0d) want %0d", c, ok, TO + 1);
        end
        runs++;
        if ({rsp_valid, rsp_err, rsp_data} !== {4'b0100, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL timeout_rsp: got rv=%b err=%b rd=%h want 0100 1 00", rsp_valid, rsp_err, rsp_data);
        end
        req = '0;
        @(negedge clk);
        runs++;
        if (busy !== 1'b0 || gnt !== '0) begin
            fails++; $display("FAIL timeout_idle: got busy=%b gnt=%b want 0 0000", busy, gnt);
        end
        m_ptr = 3;
        // finish_m on the very cycle the watchdog expires: the finish wins
        req = 4'b0100;
        wait_start(ok);
        w = 8'hC3;
        finish_after(TO + 1, w);
        runs++;
        if (!ok || {rsp_valid, rsp_err, rsp_data} !== {4'b0100, 1'b0, w}) begin
            fails++;
            $display("FAIL timeout_finish_wins: got rv=%b err=%b rd=%h want 0100 0 %h", rsp_valid, rsp_err, rsp_data, w);
        end
        req = '0;
        @(negedge clk);
        m_ptr = 3;
    endtask

    task automatic test_reset_wait();
        bit ok;
        bit seen;
        set_data(1, 8'h11);
        req = 4'b0010;
        wait_start(ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        runs++;
        if (!ok || {gnt, busy, rsp_valid} !== '0) begin
            fails++; $display("FAIL reset_wait_abort: got gnt=%b busy=%b rv=%b want 0", gnt, busy, rsp_valid);
        end
        finish_m = 1'b1; data_m_out = 8'hEE;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            finish_m = 1'b0;
            if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
        end
        runs++;
        if (seen) begin
            fails++; $display("FAIL reset_wait_no_rsp: got late activity rv=%b busy=%b want none", rsp_valid, busy);
        end
        m_ptr = 0;
        test_arbitration("post_reset", 1'b0, 4'b1010, 2, 1'b0, 1'b0);
    endtask

    task automatic test_req_drop();
        bit ok;
        logic [DW-1:0] w;
        set_data(2, 8'h5A);
        req = 4'b0100;
        wait_start(ok);
        @(negedge clk);
        req = '0;
        req_data = 32'($urandom);
        @(negedge clk);
        runs++;
        if (!ok || data_m_in !== 8'h5A || gnt !== 4'b0100) begin
            fails++; $display("FAIL req_drop_hold: got dmi=%h gnt=%b want 5a 0100", data_m_in, gnt);
        end
        w = DW'($urandom);
        finish_after(3, w);
        runs++;
        if ({rsp_valid, rsp_data, rsp_err} !== {4'b0100, w, 1'b0}) begin
            fails++;
            $display("FAIL req_drop_rsp: got rv=%b rd=%h err=%b want 0100 %h 0", rsp_valid, rsp_data, rsp_err, w);
        end
        @(negedge clk);
        m_ptr = 3;
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration("contention", 1'b1, 4'b0110, 2, 1'b0, 1'b0);
        test_arbitration("persistent", 1'b1, 4'b1111, 6, 1'b1, 1'b0);
        test_timeout();
        test_reset_wait();
        test_req_drop();
        test_arbitration("random", 1'b0, 4'($urandom) | 4'b0001, 30, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

    initial begin
        #300us;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master among `NUM_REQ` requesters. It sits between the requester blocks and the master-side ports of the SPI top level (`data_m_in`, `start_m`, `finish_m`, `data_m_out`). For each transaction it selects one requester, loads its word, and pulses `start_m`. It then waits for `finish_m` and returns the received word to that requester only. A watchdog aborts transactions whose `finish_m` never arrives.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: SPI word width; must match the master.
- `TIMEOUT`, 1023: maximum clk cycles in WAIT before abort; 0 disables the watchdog.

Ports:
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req`, in, NUM_REQ: level request per requester.
- `req_data`, in, NUM_REQ*DATA_WIDTH: TX word per requester; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`, out, NUM_REQ: one-hot owner of the current transaction.
- `rsp_valid`, out, NUM_REQ: one-hot, 1-cycle response strobe.
- `rsp_data`, out, DATA_WIDTH: RX word; valid only while `rsp_valid` is nonzero.
- `rsp_err`, out, 1: 1-cycle strobe coincident with `rsp_valid` when the transaction timed out.
- `busy`, out, 1: high in every state except IDLE.
- `start_m`, out, 1: 1-cycle start pulse to the SPI master.
- `data_m_in`, out, DATA_WIDTH: TX word to the master, held stable from LAUNCH to the end of WAIT.
- `finish_m`, in, 1: end-of-transfer pulse from the master.
- `data_m_out`, in, DATA_WIDTH: RX word from the master, valid when `finish_m` is high.

## Operation

- Reset values: all outputs are 0, the state is IDLE, the RR pointer `ptr` is 0, and the watchdog count is 0.
  - Reset asserted in any state aborts that state immediately.
  - No `rsp_valid` is issued for an aborted transaction.
- The FSM has four states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If `req` is nonzero, select the winner: the first set bit searching upward from `ptr`, wrapping past `NUM_REQ-1` to 0.
  - On that edge, register `gnt` to the winner's one-hot, register `data_m_in` to the winner's word, set `start_m`=1, and go to LAUNCH.
- LAUNCH:
  - Lasts exactly 1 cycle, with `start_m` high.
  - Clear `start_m`, clear the watchdog, and go to WAIT.
- WAIT:
  - On `finish_m`=1, latch `data_m_out` into `rsp_data`, set `rsp_valid` = `gnt`, and go to DONE.
  - Otherwise, if `TIMEOUT`≠0 and the watchdog equals `TIMEOUT-1`:
    - set `rsp_data`=0, `rsp_valid` = `gnt` and `rsp_err`=1;
    - go to DONE.
  - Otherwise increment the watchdog. The watchdog width is clog2(TIMEOUT+1) and it never wraps.
  - If `finish_m` is high on the timeout cycle, the finish wins and `rsp_err` stays 0.
- DONE:
  - Lasts exactly 1 cycle, with the response strobes high.
  - On exit, clear `rsp_valid`, `rsp_err` and `gnt`.
  - Set `ptr` to (winner index + 1) mod `NUM_REQ`, then go to IDLE.
- Handshake rules:
  - A requester holds `req` and its data until it sees its `rsp_valid` bit.
  - The requester must drop `req` in the cycle after `rsp_valid`, or it re-enters arbitration as a new request.
  - `req` or `req_data` changing after the grant does not affect the transaction in flight. The response is still delivered to the granted index.
  - `finish_m` is ignored outside WAIT.
- Fairness: with all requests held, grants rotate 0,1,…,NUM_REQ-1,0. Each requester waits at most NUM_REQ-1 transactions.

## Timing

- `req` is sampled in IDLE at edge E. `start_m` and `gnt` are high in the cycle after E.
  - `start_m` is high for exactly one cycle.
  - `gnt` stays high until the DONE exit edge.
- `finish_m` is sampled at edge F. `rsp_valid`, `rsp_err` and `rsp_data` are visible in the cycle after F.
- Back-to-back transactions spend 1 IDLE cycle between DONE and the next LAUNCH. Arbiter overhead is 3 cycles per transaction (IDLE, LAUNCH, DONE) on top of the SPI transfer.
- Timeout: `rsp_err` is visible `TIMEOUT`+1 cycles after the `start_m` cycle when no `finish_m` is seen.
- `gnt` is never multi-hot. `rsp_valid` is never nonzero outside DONE.

## Test plan

- Single request:
  - Stimulus: `req`=0001, `req_data[7:0]`=A5, with the SPI master in loopback to a slave loaded with 3C.
  - Required: `start_m` pulses 1 cycle after `req`; `data_m_in`=A5; `rsp_valid`=0001 with `rsp_data`=3C in the cycle after `finish_m`; `busy` returns to 0 two cycles after `finish_m`.
- Contention:
  - Stimulus: `req`=0110 from reset, both requests held until each sees its `rsp_valid`.
  - Required: requester 1 is granted first, then 2; `gnt` is never 0110.
- Persistent all:
  - Stimulus: `req`=1111 held for 6 transactions.
  - Required: grant order 0,1,2,3,0,1.
- Timeout:
  - Stimulus: `TIMEOUT`=16, `finish_m` tied to 0, `req`=0100.
  - Required: `rsp_valid`=0100 and `rsp_err`=1 with `rsp_data`=0, 17 cycles after `start_m`; the FSM is back in IDLE.
- Reset in WAIT:
  - Stimulus: assert `rst` for 1 cycle mid-transfer.
  - Required: next cycle `gnt`=0, `busy`=0, no `rsp_valid`; a later `req`=1000 is granted with `ptr`=0 semantics.
- Request drop:
  - Stimulus: requester 2 drops `req` during WAIT.
  - Required: the transaction completes and `rsp_valid`=0100 is still issued.
